mc_fetch_mem_unit: RTL and testbench
====================================

// Module: mc_fetch_mem_unit
// PURPOSE
// - PC / instruction-register / memory-data-register stage of the multicycle MIPS core, directly downstream of ctrl_fsm.
// - Consumes ctrl_fsm strobes (pcwrite, branch, pcsrc, iord, irwrite, memwrite).
// - Owns PC, IR, MDR and ALUOut. Arbitrates the single shared memory port with a req/ready handshake.
// - Raises o_stall while an access is outstanding; ctrl_fsm holds its state and outputs while o_stall=1.
// PARAMETERS
// - DW        32            datapath / address width
// - RESET_PC  32'h0000_0000 PC value after reset
// PORTS
// - i_clk         in   1   clock, all state on rising edge
// - i_reset       in   1   asynchronous, active-high reset
// - i_pcwrite     in   1   unconditional PC update
// - i_branch      in   1   conditional PC update (taken when i_zero=1)
// - i_pcsrc       in   2   next-PC select
// - i_iord        in   1   0: address = PC; 1: address = ALUOut
// - i_irwrite     in   1   load IR from memory (instruction fetch)
// - i_memwrite    in   1   store i_wdata to memory
// - i_alu_result  in   DW  combinational ALU output
// - i_zero        in   1   ALU zero flag
// - i_wdata       in   DW  store data (B register)
// - i_mem_ready   in   1   memory completes current access this cycle
// - i_mem_rdata   in   DW  read data, valid when i_mem_ready=1
// - o_mem_req     out  1   access request
// - o_mem_we      out  1   1 = write access
// - o_mem_addr    out  DW  access address
// - o_mem_wdata   out  DW  write data
// - o_stall       out  1   access pending, not completing this cycle
// - o_pc          out  DW  current PC
// - o_instr       out  DW  IR contents; opcode = o_instr[31:26]
// - o_mdr         out  DW  memory data register
// - o_aluout      out  DW  registered ALU result
// BEHAVIOUR
// Reset values:
// - o_pc = RESET_PC; IR, MDR and ALUOut = 0.
// - Access FSM in A_IDLE; o_mem_req = o_mem_we = o_stall = 0.
// - Reset mid-access aborts the access: o_mem_req drops immediately (async) and no IR/MDR/PC update occurs.
// Access condition:
// - need = i_irwrite | i_memwrite | (i_iord & ~i_memwrite).
// Access FSM:
// - A_IDLE, need=1:
//   - drive o_mem_req=1, o_mem_addr = i_iord ? ALUOut : PC, o_mem_we = i_memwrite, o_mem_wdata = i_wdata.
//   - i_mem_ready=1: access completes this cycle (zero-wait), stay in A_IDLE.
//   - i_mem_ready=0: latch addr/we/wdata, go to A_WAIT, o_stall=1.
// - A_WAIT:
//   - hold req/addr/we/wdata from the latched copies; o_stall = ~i_mem_ready.
//   - on i_mem_ready: complete, return to A_IDLE.
//   - strobe changes during A_WAIT are ignored.
// - done = completion cycle (ready seen while requesting).
// Completion loads:
// - IR <= i_mem_rdata if i_irwrite.
// - MDR <= i_mem_rdata on a read with i_iord=1.
// PC update:
// - pcen = (i_pcwrite | (i_branch & i_zero)) & ~o_stall. A fetch PC write therefore lands in the done cycle.
// - i_pcsrc 00 = i_alu_result; 01 = ALUOut; 10 = {PC[31:28], IR[25:0], 2'b00}; 11 = hold PC.
// ALUOut and i_memwrite:
// - ALUOut <= i_alu_result every cycle when o_stall=0; held while stalled.
// - i_memwrite with i_iord=0 is illegal. The store is still issued, to the PC address.
// BOUNDARIES
// - PC arithmetic wraps modulo 2^DW.
// - i_irwrite & i_memwrite together: the write takes priority and IR is not loaded.
// - ready asserted with no request: ignored.
// STRUCTURE
// - Shared package mips_mc_pkg:
//   - PCSRC_* encodings (00/01/10/11)
//   - opcode constants (RTYPE, LW, SW, BEQ, ADDI, JMP)
//   - access-FSM state typedef (A_IDLE, A_WAIT)
// - One natural sub-module: mc_mem_access_ctrl, containing the access FSM, the address/data latch and the stall logic.
// - PC / IR / MDR / ALUOut registers and the next-PC mux stay in the top module.
// TESTING
// - Reset: assert i_reset mid-cycle -> o_pc = 0, o_mem_req = 0 at once; IR = 0 after release.
// - Zero-wait fetch: irwrite=pcwrite=1, pcsrc=00, alu_result=4, ready=1, rdata=32'h8C01_0004 -> next edge IR = 32'h8C01_0004, PC = 4, o_stall never 1.
// - 3-wait fetch: same stimulus, ready high on 3rd cycle -> o_stall = 1 for 2 cycles, addr held = 0, PC = 4 and IR loaded only on the 3rd edge.
// - LW read: iord=1, ALUOut = 32'h40, rdata = 32'hDEAD_BEEF after 1 wait -> o_mem_addr = 32'h40, we = 0, MDR = 32'hDEAD_BEEF, IR unchanged.
// - SW: iord = memwrite = 1, i_wdata = 32'h1234 -> o_mem_we = 1, o_mem_wdata = 32'h1234, MDR and IR unchanged.
// - Branch/jump: branch=1, pcsrc=01, ALUOut = 32'h20, zero=0 -> PC holds; zero=1 -> PC = 32'h20. pcsrc=10, PC = 32'h1000_0000, IR[25:0] = 26'h10 -> PC = 32'h1000_0040.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared encodings and types for the multicycle MIPS core.
// Covers next-PC selects, opcodes and memory-access FSM states.
package mips_mc_pkg;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_JMP   = 6'h02;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_WAIT = 1'b1
  } acc_state_t;

  function automatic logic [31:0] jump_target(
    input logic [31:0] pc,
    input logic [31:0] ir
  );
    return {pc[31:28], ir[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/mc_mem_access_ctrl.sv
// Shared memory-port arbiter: req/ready handshake, request latch, stall.
// Completion strobes tell the top which register to load.
module mc_mem_access_ctrl
  import mips_mc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          irwrite,
  input  logic          memwrite,
  input  logic          iord,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] aluout,
  input  logic [DW-1:0] wdata,
  input  logic          mem_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          stall,
  output logic          load_ir,
  output logic          load_mdr
);

  acc_state_t state, state_nxt;

  logic          need;
  logic          start_wait;
  logic [DW-1:0] sel_addr;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic          ir_q;
  logic          mdr_q;

  assign need = irwrite | memwrite | (iord & ~memwrite);
  assign sel_addr = iord ? aluout : pc;
  assign start_wait = (state == A_IDLE) & need & ~mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= A_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      A_IDLE: if (need && !mem_ready) state_nxt = A_WAIT;
      A_WAIT: if (mem_ready)          state_nxt = A_IDLE;
    endcase
  end

  // Snapshot of the request; strobes are ignored until ready arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ir_q    <= 1'b0;
      mdr_q   <= 1'b0;
    end else if (start_wait) begin
      addr_q  <= sel_addr;
      wdata_q <= wdata;
      we_q    <= memwrite;
      ir_q    <= irwrite & ~memwrite;
      mdr_q   <= iord & ~memwrite;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    load_ir   = 1'b0;
    load_mdr  = 1'b0;
    unique case (state)
      A_IDLE: begin
        if (need) begin
          mem_req   = 1'b1;
          mem_we    = memwrite;
          mem_addr  = sel_addr;
          mem_wdata = wdata;
          stall     = ~mem_ready;
          load_ir   = mem_ready & irwrite & ~memwrite;
          load_mdr  = mem_ready & iord & ~memwrite;
        end
      end
      A_WAIT: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        stall     = ~mem_ready;
        load_ir   = mem_ready & ir_q;
        load_mdr  = mem_ready & mdr_q;
      end
    endcase
    // Reset aborts an access immediately, not at the next edge.
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      stall    = 1'b0;
      load_ir  = 1'b0;
      load_mdr = 1'b0;
    end
  end

endmodule

// File: rtl/mc_fetch_mem_unit.sv
// PC / IR / MDR / ALUOut stage of the multicycle MIPS core.
// Memory port arbitration lives in mc_mem_access_ctrl.
module mc_fetch_mem_unit
  import mips_mc_pkg::*;
#(
  parameter int          DW       = 32,
  parameter logic [DW-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_pcwrite,
  input  logic          i_branch,
  input  logic [1:0]    i_pcsrc,
  input  logic          i_iord,
  input  logic          i_irwrite,
  input  logic          i_memwrite,
  input  logic [DW-1:0] i_alu_result,
  input  logic          i_zero,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_mem_ready,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_stall,
  output logic [DW-1:0] o_pc,
  output logic [DW-1:0] o_instr,
  output logic [DW-1:0] o_mdr,
  output logic [DW-1:0] o_aluout
);

  logic [DW-1:0] pc_q, ir_q, mdr_q, aluout_q;
  logic [DW-1:0] pc_nxt;
  logic          pcen;
  logic          stall;
  logic          load_ir;
  logic          load_mdr;

  mc_mem_access_ctrl #(.DW(DW)) u_acc (
    .clk       (i_clk),
    .rst       (i_reset),
    .irwrite   (i_irwrite),
    .memwrite  (i_memwrite),
    .iord      (i_iord),
    .pc        (pc_q),
    .aluout    (aluout_q),
    .wdata     (i_wdata),
    .mem_ready (i_mem_ready),
    .mem_req   (o_mem_req),
    .mem_we    (o_mem_we),
    .mem_addr  (o_mem_addr),
    .mem_wdata (o_mem_wdata),
    .stall     (stall),
    .load_ir   (load_ir),
    .load_mdr  (load_mdr)
  );

  assign pcen = (i_pcwrite | (i_branch & i_zero)) & ~stall;

  always_comb begin
    pc_nxt = pc_q;
    unique case (i_pcsrc)
      PCSRC_ALU:    pc_nxt = i_alu_result;
      PCSRC_ALUOUT: pc_nxt = aluout_q;
      PCSRC_JUMP:   pc_nxt = jump_target(pc_q, ir_q);
      PCSRC_HOLD:   pc_nxt = pc_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) pc_q <= RESET_PC;
    else if (pcen) pc_q <= pc_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ir_q     <= '0;
      mdr_q    <= '0;
      aluout_q <= '0;
    end else begin
      if (load_ir)  ir_q  <= i_mem_rdata;
      if (load_mdr) mdr_q <= i_mem_rdata;
      if (!stall)   aluout_q <= i_alu_result;
    end
  end

  assign o_stall  = stall;
  assign o_pc     = pc_q;
  assign o_instr  = ir_q;
  assign o_mdr    = mdr_q;
  assign o_aluout = aluout_q;

endmodule

// File: tb/tb_mc_fetch_mem_unit.sv
// Directed bench for mc_fetch_mem_unit: fetch, load, store, branch, jump.
// Expected values are hand-computed constants.
module tb_mc_fetch_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcwrite, branch, iord, irwrite, memwrite, zero, ready;
  logic [1:0]  pcsrc;
  logic [31:0] alu_result, wdata, rdata;
  logic        mem_req, mem_we, stall;
  logic [31:0] mem_addr, mem_wdata, pc, instr, mdr, aluout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mc_fetch_mem_unit dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_pcwrite    (pcwrite),
    .i_branch     (branch),
    .i_pcsrc      (pcsrc),
    .i_iord       (iord),
    .i_irwrite    (irwrite),
    .i_memwrite   (memwrite),
    .i_alu_result (alu_result),
    .i_zero       (zero),
    .i_wdata      (wdata),
    .i_mem_ready  (ready),
    .i_mem_rdata  (rdata),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_stall      (stall),
    .o_pc         (pc),
    .o_instr      (instr),
    .o_mdr        (mdr),
    .o_aluout     (aluout)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pcwrite = 0; branch = 0; iord = 0; irwrite = 0;
    memwrite = 0; zero = 0; ready = 0; pcsrc = 2'b00;
  endtask

  initial begin
    idle();
    alu_result = 0; wdata = 0; rdata = 0;
    rst = 1;
    step(); step();
    #2 rst = 0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", instr, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_aluout", aluout, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    step();

    // zero-wait fetch
    irwrite = 1; pcwrite = 1; alu_result = 32'h4;
    ready = 1; rdata = 32'h8C01_0004;
    #1;
    chk("zw_req", {31'b0, mem_req}, 32'h1);
    chk("zw_addr", mem_addr, 32'h0);
    chk("zw_we", {31'b0, mem_we}, 32'h0);
    chk("zw_stall", {31'b0, stall}, 32'h0);
    step();
    chk("zw_ir", instr, 32'h8C01_0004);
    chk("zw_pc", pc, 32'h4);
    idle();

    // reset in the middle of a pending fetch
    irwrite = 1; pcwrite = 1; alu_result = 32'h8;
    step();
    chk("ab_stall", {31'b0, stall}, 32'h1);
    chk("ab_pc", pc, 32'h4);
    #2 rst = 1;
    #1;
    chk("ab_req", {31'b0, mem_req}, 32'h0);
    chk("ab_pc0", pc, 32'h0);
    idle();
    step();
    #2 rst = 0;
    #1;
    chk("ab_ir", instr, 32'h0);
    step();

    // three-cycle fetch, ready on the third cycle
    irwrite = 1; pcwrite = 1; alu_result = 32'h4;
    ready = 0; rdata = 32'h8C01_0004;
    #1;
    chk("w3_stall1", {31'b0, stall}, 32'h1);
    chk("w3_addr1", mem_addr, 32'h0);
    step();
    iord = 1;
    #1;
    chk("w3_stall2", {31'b0, stall}, 32'h1);
    chk("w3_addr2", mem_addr, 32'h0);
    chk("w3_pc2", pc, 32'h0);
    chk("w3_ir2", instr, 32'h0);
    step();
    iord = 0; ready = 1;
    #1;
    chk("w3_stall3", {31'b0, stall}, 32'h0);
    chk("w3_req3", {31'b0, mem_req}, 32'h1);
    step();
    chk("w3_pc", pc, 32'h4);
    chk("w3_ir", instr, 32'h8C01_0004);
    chk("w3_mdr", mdr, 32'h0);
    idle();

    // LW with one wait state
    alu_result = 32'h40;
    step();
    chk("lw_aluout", aluout, 32'h40);
    iord = 1; alu_result = 32'h0;
    #1;
    chk("lw_addr", mem_addr, 32'h40);
    chk("lw_we", {31'b0, mem_we}, 32'h0);
    chk("lw_stall", {31'b0, stall}, 32'h1);
    step();
    chk("lw_hold", aluout, 32'h40);
    ready = 1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw_addr2", mem_addr, 32'h40);
    step();
    chk("lw_mdr", mdr, 32'hDEAD_BEEF);
    chk("lw_ir", instr, 32'h8C01_0004);
    idle();

    // SW, zero-wait
    alu_result = 32'h80;
    step();
    iord = 1; memwrite = 1; wdata = 32'h1234;
    ready = 1; rdata = 32'h5555_5555;
    #1;
    chk("sw_we", {31'b0, mem_we}, 32'h1);
    chk("sw_wdata", mem_wdata, 32'h1234);
    chk("sw_addr", mem_addr, 32'h80);
    step();
    chk("sw_mdr", mdr, 32'hDEAD_BEEF);
    chk("sw_ir", instr, 32'h8C01_0004);

    // write wins over IR load
    irwrite = 1; rdata = 32'hAAAA_AAAA;
    step();
    chk("wir_ir", instr, 32'h8C01_0004);
    idle();

    // ready with no request
    ready = 1; rdata = 32'h7777_7777;
    #1;
    chk("nr_req", {31'b0, mem_req}, 32'h0);
    step();
    chk("nr_mdr", mdr, 32'hDEAD_BEEF);
    idle();

    // conditional branch
    alu_result = 32'h20;
    step();
    branch = 1; pcsrc = 2'b01; zero = 0;
    step();
    chk("br_nt", pc, 32'h4);
    zero = 1;
    step();
    chk("br_t", pc, 32'h20);
    idle();

    // jump
    pcwrite = 1; alu_result = 32'h1000_0000;
    step();
    chk("j_pcset", pc, 32'h1000_0000);
    idle();
    irwrite = 1; ready = 1; rdata = 32'h0800_0010;
    #1;
    chk("j_faddr", mem_addr, 32'h1000_0000);
    step();
    chk("j_ir", instr, 32'h0800_0010);
    idle();
    pcwrite = 1; pcsrc = 2'b10;
    step();
    chk("j_pc", pc, 32'h1000_0040);
    pcsrc = 2'b11;
    step();
    chk("hold_pc", pc, 32'h1000_0040);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
